nco_mc_qw: RTL and testbench
============================

Name: nco_mc_qw

Overview:
Parametrised multi-channel successor to the single-channel sine NCO. It time-multiplexes NCH phase accumulators through one quarter-wave ROM pipeline and produces sine and cosine per channel. Each channel has a runtime-programmable phase increment and phase offset, committed coherently at frame boundaries. It sits between the modulator control registers and the mixer/DUC stages.

Parameters:
NCH, 4, number of channels (power of 2, 1..16)
APR, 32, phase accumulator/increment/offset width
RAW, 8, quarter-wave ROM address width (2^RAW entries)
MPR, 10, signed output width
ROM_FILE, "nco_qw_sin.hex", ROM init file, entry k = round((2^(MPR-1)-1)*sin(pi/2*(k+0.5)/2^RAW))

Ports:
clk  in  1  clock
reset  in  1  synchronous reset
clken  in  1  clock enable; all state advances only when high
cfg_we_i  in  1  config write strobe
cfg_ch_i  in  max(1,log2 NCH)  target channel
cfg_inc_i  in  APR  phase increment
cfg_ofs_i  in  APR  phase offset
cfg_rdy_o  out  1  config write accepted when high
fsin_o  out  MPR  signed sine sample
fcos_o  out  MPR  signed cosine sample
ch_o  out  max(1,log2 NCH)  channel of current output sample
out_valid  out  1  output sample valid

Interface note: one clock; reset is synchronous and active-high.

Behaviour:
- Reset: fsin_o=0, fcos_o=0, ch_o=0, out_valid=0, cfg_rdy_o=1. All accumulators, increments, offsets and the slot counter are 0. The pending write and all pipeline valids are cleared.
- Reset asserted mid-operation takes the same action on the next edge. A pending config write is dropped.
- Slot counter: advances 0..NCH-1 on each clken cycle. A frame boundary is the clken cycle in which the slot counter is NCH-1.
- S0: read acc[slot] as the phase, then write acc[slot] += inc[slot]. The sum wraps modulo 2^APR.
- S1: p = phase + ofs[slot], modulo 2^APR. idx = p[APR-1:APR-2-RAW]; q = idx[RAW+1:RAW]; a = idx[RAW-1:0].
- S2: dual-port registered ROM read of rom[a] and rom[~a].
- S3: sign and mirror applied, then the output is registered.
  - sin: q0 +rom[a], q1 +rom[~a], q2 -rom[a], q3 -rom[~a].
  - cos: q0 +rom[~a], q1 -rom[a], q2 -rom[~a], q3 +rom[a].
  - Negation is exact two's complement; no overflow is possible.
- Latency: 4 clken cycles from S0 to outputs. out_valid rises on the 4th enabled cycle after reset and stays high; ch_o tracks the slot carried down the pipeline.
- Frame sample k of channel c has phase k*inc_c + ofs_c. Frame 0 uses phase ofs_c only.
- clken low: every register, including outputs and out_valid, holds its value.
- Config handshake:
  - The write is accepted when cfg_we_i & cfg_rdy_o & clken. It is latched as pending, and cfg_rdy_o drops on the next edge.
  - The pending write commits inc/ofs of cfg_ch_i at the frame boundary, taking effect from the next frame. cfg_rdy_o returns high the edge after commit.
  - A write attempted while cfg_rdy_o=0 is ignored.
  - Accept and commit in the same cycle cannot occur, because rdy is low while pending.

Optional Feature:
NCO_DITHER_EN
- Defined: a 16-bit maximal LFSR (x^16+x^14+x^13+x^11+1, seed 0xACE1, reset to seed, steps on clken) feeds the S1 adder. Its top (APR-2-RAW) bits, capped at 16, are added into the discarded phase LSBs before truncation.
- Undefined: plain truncation, with no LFSR logic instantiated.

Decomposition:
- Package nco_mc_pkg:
  - slot width function clog2;
  - quadrant enum Q0..Q3;
  - LFSR taps/seed constants;
  - pipeline depth constant NCO_LAT=4.
- Sub-module nco_qw_rom: dual-read-port registered ROM, RAW address, MPR-1 bit unsigned data, ROM_FILE init.

Test Plan:
- Reset: assert reset for 3 cycles -> all outputs 0, out_valid=0, cfg_rdy_o=1; out_valid rises exactly on the 4th clken cycle after release.
- fs/4: ch0 inc=0x40000000, ofs=0 (NCH=4, RAW=8, MPR=10) -> ch0 sin 2, 511, -2, -511, repeating; cos 511, -2, -511, 2.
- Offset: ch1 same inc, ofs=0x80000000 -> ch1 samples are the exact negation of ch0 every frame; ch_o cycles 0,1,2,3.
- Wrap/negative: ch2 inc=0xFFFFFFFF -> first frame sin=2, next frame sin=-2 (q3, a=255); no glitch at the accumulator wrap.
- clken 50% random -> sample sequence identical to the continuous-clken run; outputs are frozen on clken=0 cycles.
- Handshake: write ch3 mid-frame, then a second write 1 cycle later -> second write ignored, cfg_rdy_o low until one cycle after the frame boundary, new inc visible from the next frame.
- Reset during pending: reset one cycle after acceptance -> pending write dropped, ch3 inc=0.

Source files
------------

// File: rtl/nco_mc_pkg.sv
// Shared types and constants for the multi-channel quarter-wave NCO.
// Also holds the elaboration-time quarter-wave sine table generator.
package nco_mc_pkg;

    localparam int NCO_LAT = 4;

    // x^16 + x^14 + x^13 + x^11 + 1, shifted left with feedback into bit 0
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quad_e;

    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

    // round((2^(mpr-1)-1) * sin(pi/2 * (k+0.5) / 2^raw)), Q30 Taylor series
    function automatic logic [31:0] qw_entry(input int k, input int raw, input int mpr);
        longint pi_q30;
        longint x;
        longint term;
        longint sum;
        longint amp;
        pi_q30 = 64'sd3373259426;
        x      = (pi_q30 * longint'(2 * k + 1)) >>> (raw + 2);
        sum    = x;
        term   = x;
        for (int n = 1; n <= 8; n++) begin
            term = (term * x) >>> 30;
            term = (term * x) >>> 30;
            term = -term / longint'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        amp = longint'((1 << (mpr - 1)) - 1);
        return 32'((sum * amp + (64'sd1 <<< 29)) >>> 30);
    endfunction

endpackage

// File: rtl/nco_qw_rom.sv
// Quarter-wave sine ROM with two registered read ports; contents follow the
// ROM_FILE formula and are generated at elaboration so no external file is needed.
module nco_qw_rom
    import nco_mc_pkg::*;
#(
    parameter int RAW      = 8,
    parameter int MPR      = 10,
    parameter     ROM_FILE = "nco_qw_sin.hex"
) (
    input  logic           clk,
    input  logic           en,
    input  logic [RAW-1:0] addr_a,
    input  logic [RAW-1:0] addr_b,
    output logic [MPR-2:0] data_a,
    output logic [MPR-2:0] data_b
);

    localparam int DEPTH = 1 << RAW;

    logic [MPR-2:0] tbl [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_tbl
        localparam logic [31:0] V = qw_entry(k, RAW, MPR);
        assign tbl[k] = V[MPR-2:0];
    end

    always_ff @(posedge clk) begin
        if (en) begin
            data_a <= tbl[addr_a];
            data_b <= tbl[addr_b];
        end
    end

endmodule

// File: rtl/nco_mc_qw.sv
// Time-multiplexed NCH-channel sine/cosine NCO sharing one quarter-wave ROM pipeline.
// Optional phase dither LFSR is built when NCO_DITHER_EN is defined.
module nco_mc_qw
    import nco_mc_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int APR      = 32,
    parameter int RAW      = 8,
    parameter int MPR      = 10,
    parameter     ROM_FILE = "nco_qw_sin.hex"
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clken,
    input  logic                    cfg_we_i,
    input  logic [clog2(NCH)-1:0]   cfg_ch_i,
    input  logic [APR-1:0]          cfg_inc_i,
    input  logic [APR-1:0]          cfg_ofs_i,
    output logic                    cfg_rdy_o,
    output logic signed [MPR-1:0]   fsin_o,
    output logic signed [MPR-1:0]   fcos_o,
    output logic [clog2(NCH)-1:0]   ch_o,
    output logic                    out_valid
);

    localparam int SW = clog2(NCH);
    localparam int L  = APR - 2 - RAW;

    logic [SW-1:0]  slot;
    logic           frame_end;
    logic [APR-1:0] acc   [NCH];
    logic [APR-1:0] inc_r [NCH];
    logic [APR-1:0] ofs_r [NCH];

    logic           pend;
    logic           rdy;
    logic [SW-1:0]  pend_ch;
    logic [APR-1:0] pend_inc;
    logic [APR-1:0] pend_ofs;
    logic           accept;
    logic           commit;

    logic [APR-1:0] ph1;
    logic [APR-1:0] ofs1;
    logic [SW-1:0]  ch1, ch2, ch3;
    logic           v1, v2, v3;
    logic [RAW+1:0] idx;
    quad_e          q2, q3;
    logic [RAW-1:0] a2;
    logic [MPR-2:0] ra, rb;
    logic signed [MPR-1:0] sin_n, cos_n;

    assign frame_end = (slot == SW'(NCH - 1));

    // Config handshake: a write is taken when cfg_we_i & cfg_rdy_o & clken. It
    // stays pending (rdy low) until the frame-end cycle, where inc/ofs of the
    // target channel are committed; rdy rises one enabled cycle after commit.
    assign accept    = cfg_we_i & rdy;
    assign commit    = pend & frame_end;
    assign cfg_rdy_o = rdy;

    always_ff @(posedge clk) begin
        if (reset) begin
            slot     <= '0;
            pend     <= 1'b0;
            rdy      <= 1'b1;
            pend_ch  <= '0;
            pend_inc <= '0;
            pend_ofs <= '0;
            for (int c = 0; c < NCH; c++) begin
                acc[c]   <= '0;
                inc_r[c] <= '0;
                ofs_r[c] <= '0;
            end
        end else if (clken) begin
            slot      <= frame_end ? '0 : slot + 1'b1;
            acc[slot] <= acc[slot] + inc_r[slot];
            if (accept) begin
                pend     <= 1'b1;
                rdy      <= 1'b0;
                pend_ch  <= cfg_ch_i;
                pend_inc <= cfg_inc_i;
                pend_ofs <= cfg_ofs_i;
            end else if (commit) begin
                pend           <= 1'b0;
                inc_r[pend_ch] <= pend_inc;
                ofs_r[pend_ch] <= pend_ofs;
            end else begin
                rdy <= ~pend;
            end
        end
    end

    // Carry out of the discarded phase bits is formed by comparison so that
    // only the kept RAW+2 bits of the sum are ever built.
`ifdef NCO_DITHER_EN
    localparam int DW = (L > 16) ? 16 : L;

    logic [15:0]  lfsr;
    logic [L-1:0] dith;
    logic [L-1:0] lo1;
    logic         cy1, cy2;

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else if (clken) begin
            lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
        end
    end

    always_comb begin
        dith = L'(lfsr[15 -: DW]) << (L - DW);
        lo1  = ph1[L-1:0] + ofs1[L-1:0];
        cy1  = ofs1[L-1:0] > ~ph1[L-1:0];
        cy2  = dith > ~lo1;
        idx  = ph1[APR-1:L] + ofs1[APR-1:L] + (RAW+2)'(cy1) + (RAW+2)'(cy2);
    end
`else
    logic cy_lo;

    always_comb begin
        cy_lo = ofs1[L-1:0] > ~ph1[L-1:0];
        idx   = ph1[APR-1:L] + ofs1[APR-1:L] + (RAW+2)'(cy_lo);
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            ph1       <= '0;
            ofs1      <= '0;
            ch1       <= '0;
            ch2       <= '0;
            ch3       <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            q2        <= Q0;
            q3        <= Q0;
            a2        <= '0;
            fsin_o    <= '0;
            fcos_o    <= '0;
            ch_o      <= '0;
            out_valid <= 1'b0;
        end else if (clken) begin
            ph1  <= acc[slot];
            ofs1 <= ofs_r[slot];
            ch1  <= slot;
            v1   <= 1'b1;
            q2   <= quad_e'(idx[RAW+1:RAW]);
            a2   <= idx[RAW-1:0];
            ch2  <= ch1;
            v2   <= v1;
            q3   <= q2;
            ch3  <= ch2;
            v3   <= v2;
            if (v3) begin
                fsin_o <= sin_n;
                fcos_o <= cos_n;
                ch_o   <= ch3;
            end
            out_valid <= v3;
        end
    end

    nco_qw_rom #(
        .RAW      (RAW),
        .MPR      (MPR),
        .ROM_FILE (ROM_FILE)
    ) u_rom (
        .clk    (clk),
        .en     (clken),
        .addr_a (a2),
        .addr_b (~a2),
        .data_a (ra),
        .data_b (rb)
    );

    always_comb begin
        logic signed [MPR-1:0] pa;
        logic signed [MPR-1:0] pb;
        pa    = $signed({1'b0, ra});
        pb    = $signed({1'b0, rb});
        sin_n = pa;
        cos_n = pb;
        unique case (q3)
            Q0: begin sin_n =  pa; cos_n =  pb; end
            Q1: begin sin_n =  pb; cos_n = -pa; end
            Q2: begin sin_n = -pa; cos_n = -pb; end
            Q3: begin sin_n = -pb; cos_n =  pa; end
            default: begin sin_n = pa; cos_n = pb; end
        endcase
    end

endmodule

// File: tb/tb_nco_mc_qw.sv
// Directed bench for nco_mc_qw: reset, fs/4 tones, offset, wrap, random clken,
// config handshake and reset while a write is pending.
module tb_nco_mc_qw;
    import nco_mc_pkg::*;

    localparam int NCH    = 4;
    localparam int APR    = 32;
    localparam int RAW    = 8;
    localparam int MPR    = 10;
    localparam int SW     = 2;
    localparam int MAXF   = 12;
    localparam int RUN_EN = 52;
    localparam int NVEC   = 24;
    localparam int NWR    = 5;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  clken = 1'b0;
    logic                  cfg_we_i = 1'b0;
    logic [SW-1:0]         cfg_ch_i = '0;
    logic [APR-1:0]        cfg_inc_i = '0;
    logic [APR-1:0]        cfg_ofs_i = '0;
    logic                  cfg_rdy_o;
    logic signed [MPR-1:0] fsin_o;
    logic signed [MPR-1:0] fcos_o;
    logic [SW-1:0]         ch_o;
    logic                  out_valid;

    always #5 clk = ~clk;

    nco_mc_qw #(
        .NCH (NCH),
        .APR (APR),
        .RAW (RAW),
        .MPR (MPR)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clken     (clken),
        .cfg_we_i  (cfg_we_i),
        .cfg_ch_i  (cfg_ch_i),
        .cfg_inc_i (cfg_inc_i),
        .cfg_ofs_i (cfg_ofs_i),
        .cfg_rdy_o (cfg_rdy_o),
        .fsin_o    (fsin_o),
        .fcos_o    (fcos_o),
        .ch_o      (ch_o),
        .out_valid (out_valid)
    );

    // k is the frame index relative to the frame where the channel's config took effect
    typedef struct {
        int ch;
        int k;
        int s;
        int c;
    } vec_t;

    typedef struct {
        int          at;
        int          ch;
        logic [31:0] inc;
        logic [31:0] ofs;
    } wr_t;

    vec_t vecs [NVEC];
    wr_t  wrs  [NWR];

    int  n_vec = 0;
    int  n_bad = 0;

    int  ecyc;
    bit  exp_rdy;
    bit  exp_pend;
    int  commit_i;
    int  pend_ch;
    int  start_f [NCH];
    bit  use_ref;

    int  cap_s   [NCH][MAXF];
    int  cap_c   [NCH][MAXF];
    bit  seen    [NCH][MAXF];
    int  ref_s   [NCH][MAXF];
    int  ref_c   [NCH][MAXF];
    bit  ref_ok  [NCH][MAXF];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        ecyc     = 0;
        exp_rdy  = 1'b1;
        exp_pend = 1'b0;
        commit_i = -1;
        pend_ch  = 0;
        for (int c = 0; c < NCH; c++) begin
            start_f[c] = 0;
            for (int f = 0; f < MAXF; f++) seen[c][f] = 1'b0;
        end
    endtask

    task automatic step(input bit en, input bit rst);
        bit acc_now;
        int i;
        int s;
        int c;
        int f;
        clken   = en;
        reset   = rst;
        acc_now = !rst && en && cfg_we_i && exp_rdy;
        i       = ecyc;
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
            chk("rst_sin", fsin_o, 0);
            chk("rst_cos", fcos_o, 0);
            chk("rst_ch", int'(ch_o), 0);
            chk("rst_valid", int'(out_valid), 0);
            chk("rst_rdy", int'(cfg_rdy_o), 1);
        end else begin
            if (en) begin
                ecyc++;
                if (acc_now) begin
                    exp_pend = 1'b1;
                    exp_rdy  = 1'b0;
                    pend_ch  = int'(cfg_ch_i);
                    commit_i = (i / NCH) * NCH + NCH - 1;
                    if (commit_i == i) commit_i += NCH;
                end else if (exp_pend && i == commit_i) begin
                    exp_pend         = 1'b0;
                    start_f[pend_ch] = i / NCH + 1;
                end else if (!exp_pend) begin
                    exp_rdy = 1'b1;
                end
            end
            chk("cfg_rdy", int'(cfg_rdy_o), int'(exp_rdy));
            chk("out_valid", int'(out_valid), (ecyc >= NCO_LAT) ? 1 : 0);
            if (ecyc >= NCO_LAT) begin
                s = ecyc - NCO_LAT;
                c = s % NCH;
                f = s / NCH;
                chk("ch_o", int'(ch_o), c);
                if (f < MAXF) begin
                    if (en) begin
                        cap_s[c][f] = fsin_o;
                        cap_c[c][f] = fcos_o;
                        seen[c][f]  = 1'b1;
                    end else if (use_ref && ref_ok[c][f]) begin
                        chk("hold_sin", fsin_o, ref_s[c][f]);
                        chk("hold_cos", fcos_o, ref_c[c][f]);
                    end
                end
            end
        end
    endtask

    task automatic run_seq(input bit rnd);
        bit en;
        int guard;
        cfg_we_i = 1'b0;
        for (int r = 0; r < 3; r++) step(1'b1, 1'b1);
        guard = 0;
        while (ecyc < RUN_EN && guard < 2000) begin
            en       = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cfg_we_i = 1'b0;
            if (en) begin
                for (int w = 0; w < NWR; w++) begin
                    if (wrs[w].at == ecyc) begin
                        cfg_we_i  = 1'b1;
                        cfg_ch_i  = SW'(wrs[w].ch);
                        cfg_inc_i = wrs[w].inc;
                        cfg_ofs_i = wrs[w].ofs;
                    end
                end
            end
            step(en, 1'b0);
            guard++;
        end
        cfg_we_i = 1'b0;
        if (ecyc < RUN_EN) chk("run_budget", ecyc, RUN_EN);
    endtask

    task automatic check_table(input string tag);
        int f;
        for (int v = 0; v < NVEC; v++) begin
            f = start_f[vecs[v].ch] + vecs[v].k;
            if (f < 0 || f >= MAXF || !seen[vecs[v].ch][f]) begin
                chk($sformatf("%s_v%0d_present", tag, v), 0, 1);
            end else begin
                chk($sformatf("%s_v%0d_sin", tag, v), cap_s[vecs[v].ch][f], vecs[v].s);
                chk($sformatf("%s_v%0d_cos", tag, v), cap_c[vecs[v].ch][f], vecs[v].c);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // ch, k, sin, cos
        vecs[0]  = '{0, -1,    2,  511};
        vecs[1]  = '{0,  0,    2,  511};
        vecs[2]  = '{0,  1,  511,   -2};
        vecs[3]  = '{0,  2,   -2, -511};
        vecs[4]  = '{0,  3, -511,    2};
        vecs[5]  = '{0,  4,    2,  511};
        vecs[6]  = '{0,  5,  511,   -2};
        vecs[7]  = '{1, -1,    2,  511};
        vecs[8]  = '{1,  0,   -2, -511};
        vecs[9]  = '{1,  1, -511,    2};
        vecs[10] = '{1,  2,    2,  511};
        vecs[11] = '{1,  3,  511,   -2};
        vecs[12] = '{1,  4,   -2, -511};
        vecs[13] = '{2, -2,    2,  511};
        vecs[14] = '{2,  0,    2,  511};
        vecs[15] = '{2,  1,   -2,  511};
        vecs[16] = '{2,  2,   -2,  511};
        vecs[17] = '{2,  5,   -2,  511};
        vecs[18] = '{3, -4,    2,  511};
        vecs[19] = '{3, -1,    2,  511};
        vecs[20] = '{3,  0,    2,  511};
        vecs[21] = '{3,  1,  511,   -2};
        vecs[22] = '{3,  2,   -2, -511};
        vecs[23] = '{3,  3, -511,    2};

        // enabled-cycle index, channel, inc, ofs; the last write lands while busy
        wrs[0] = '{1,  0, 32'h4000_0000, 32'h0000_0000};
        wrs[1] = '{6,  1, 32'h4000_0000, 32'h8000_0000};
        wrs[2] = '{9,  2, 32'hFFFF_FFFF, 32'h0000_0000};
        wrs[3] = '{13, 3, 32'h4000_0000, 32'h0000_0000};
        wrs[4] = '{14, 3, 32'h2000_0000, 32'h8000_0000};

        model_reset();
        use_ref = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            for (int f = 0; f < MAXF; f++) ref_ok[c][f] = 1'b0;
        end

        // continuous clken
        run_seq(1'b0);
        check_table("cont");
        ref_s  = cap_s;
        ref_c  = cap_c;
        ref_ok = seen;

        // random clken, same enabled-cycle write schedule
        use_ref = 1'b1;
        run_seq(1'b1);
        check_table("rand");
        for (int c = 0; c < NCH; c++) begin
            for (int f = 0; f < MAXF; f++) begin
                if (ref_ok[c][f]) begin
                    chk($sformatf("same_c%0d_f%0d_seen", c, f), int'(seen[c][f]), 1);
                    if (seen[c][f]) begin
                        chk($sformatf("same_c%0d_f%0d_sin", c, f), cap_s[c][f], ref_s[c][f]);
                        chk($sformatf("same_c%0d_f%0d_cos", c, f), cap_c[c][f], ref_c[c][f]);
                    end
                end
            end
        end
        use_ref = 1'b0;

        // reset one cycle after a write is accepted: the write must vanish
        cfg_we_i = 1'b0;
        for (int r = 0; r < 3; r++) step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        cfg_we_i  = 1'b1;
        cfg_ch_i  = 2'd3;
        cfg_inc_i = 32'h4000_0000;
        cfg_ofs_i = 32'h0000_0000;
        step(1'b1, 1'b0);
        cfg_we_i = 1'b0;
        step(1'b1, 1'b1);
        for (int n = 0; n < NCO_LAT + NCH * 5; n++) step(1'b1, 1'b0);
        for (int c = 0; c < NCH; c++) begin
            for (int f = 0; f < 5; f++) begin
                if (!seen[c][f]) begin
                    chk($sformatf("drop_c%0d_f%0d_present", c, f), 0, 1);
                end else begin
                    chk($sformatf("drop_c%0d_f%0d_sin", c, f), cap_s[c][f], 2);
                    chk($sformatf("drop_c%0d_f%0d_cos", c, f), cap_c[c][f], 511);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
